// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - MDUOp encodings and opcode-class helpers shared by the MDU and its decoders
package mdu_pkg;

   localparam logic [3:0] OP_NONE  = 4'd0;
   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MFHI  = 4'd5;
   localparam logic [3:0] OP_MFLO  = 4'd6;
   localparam logic [3:0] OP_MTHI  = 4'd7;
   localparam logic [3:0] OP_MTLO  = 4'd8;

   function automatic logic is_long_op(input logic [3:0] op);
      return (op >= OP_MULT) && (op <= OP_DIVU);
   endfunction

   function automatic logic is_div_op(input logic [3:0] op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

endpackage

// File: rtl/mdu.sv
// rtl/mdu.sv - multiply/divide unit owning HI/LO with modelled multi-cycle latency
import mdu_pkg::*;

module mdu #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  MDUOp,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        req,
   output logic        start,
   output logic        busy,
   output logic [31:0] out
);

   localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);

   logic [31:0]        r_hi, r_lo, r_pend_hi, r_pend_lo;
   logic [CW-1:0]      r_count;
   logic               r_skip_wr;

   logic               w_b_zero;
   logic [31:0]        w_b_safe;
   logic signed [63:0] w_smul;
   logic [63:0]        w_umul;
   logic signed [31:0] w_sa, w_sb, w_squo, w_srem;
   logic [31:0]        w_uquo, w_urem;
   logic [63:0]        w_result;

   // Divisor forced to 1 when zero so the dividers never produce X; the write is suppressed instead.
   assign w_b_zero = (B == 32'd0);
   assign w_b_safe = w_b_zero ? 32'd1 : B;

   assign w_smul = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
   assign w_umul = {32'd0, A} * {32'd0, B};
   assign w_sa   = $signed(A);
   assign w_sb   = $signed(w_b_safe);
   assign w_squo = w_sa / w_sb;
   assign w_srem = w_sa % w_sb;
   assign w_uquo = A / w_b_safe;
   assign w_urem = A % w_b_safe;

   always_comb begin
      w_result = 64'd0;
      case (MDUOp)
         OP_MULT:  w_result = w_smul;
         OP_MULTU: w_result = w_umul;
         OP_DIV:   w_result = {w_srem, w_squo};
         OP_DIVU:  w_result = {w_urem, w_uquo};
         default:  w_result = 64'd0;
      endcase
   end

   assign busy  = (r_count != '0);
   assign start = is_long_op(MDUOp) && !busy && !req;

   always_comb begin
      out = 32'd0;
      if (MDUOp == OP_MFHI) out = r_hi;
      else if (MDUOp == OP_MFLO) out = r_lo;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_hi      <= 32'd0;
         r_lo      <= 32'd0;
         r_pend_hi <= 32'd0;
         r_pend_lo <= 32'd0;
         r_count   <= '0;
         r_skip_wr <= 1'b0;
      end else begin
         if (start) begin
            r_pend_hi <= w_result[63:32];
            r_pend_lo <= w_result[31:0];
            r_count   <= is_div_op(MDUOp) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            r_skip_wr <= is_div_op(MDUOp) && w_b_zero;
         end else if (busy) begin
            r_count <= r_count - CW'(1);
            if ((r_count == CW'(1)) && !r_skip_wr) begin
               r_hi <= r_pend_hi;
               r_lo <= r_pend_lo;
            end
         end

         if (!busy && !req) begin
            if (MDUOp == OP_MTHI) r_hi <= A;
            if (MDUOp == OP_MTLO) r_lo <= A;
         end
      end
   end

endmodule

// File: tb/tb_mdu.sv
// tb/tb_mdu.sv - directed self-checking bench for the multiply/divide unit
module tb_mdu;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  MDUOp;
   logic [31:0] A, B;
   logic        req;
   logic        start, busy;
   logic [31:0] out;

   int errors = 0;
   int checks = 0;
   int n;

   mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset(reset), .MDUOp(MDUOp), .A(A), .B(B), .req(req),
      .start(start), .busy(busy), .out(out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_hilo(input string tag, input logic [31:0] ehi, input logic [31:0] elo);
      logic [3:0] save;
      save = MDUOp;
      MDUOp = 4'd5; #1; check({tag, " HI"}, out, ehi);
      MDUOp = 4'd6; #1; check({tag, " LO"}, out, elo);
      MDUOp = save; #1;
   endtask

   task automatic move_to(input logic [3:0] op, input logic [31:0] a);
      MDUOp = op; A = a; #1;
      step();
      MDUOp = 4'd0;
   endtask

   task automatic issue(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      MDUOp = op; A = a; B = b; #1;
      check({tag, " start"}, {31'd0, start}, 32'd1);
      step();
      MDUOp = 4'd0;
   endtask

   task automatic wait_idle(output int cnt);
      cnt = 0;
      while (busy && cnt < 50) begin
         step();
         cnt++;
      end
   endtask

   initial begin
      reset = 1'b1; MDUOp = 4'd0; A = 32'd0; B = 32'd0; req = 1'b0;
      step(); step();
      reset = 1'b0; #1;
      check("reset busy", {31'd0, busy}, 32'd0);
      check("reset start", {31'd0, start}, 32'd0);
      check("reset out", out, 32'd0);
      check_hilo("reset", 32'd0, 32'd0);

      // 1: reset mid-divide aborts and leaves no late write
      move_to(4'd7, 32'h55);
      move_to(4'd8, 32'h66);
      issue("t1", 4'd3, 32'd100, 32'd7);
      step(); step(); step();
      reset = 1'b1; step(); step(); reset = 1'b0; #1;
      check("t1 busy", {31'd0, busy}, 32'd0);
      check_hilo("t1 after reset", 32'd0, 32'd0);
      repeat (12) step();
      check_hilo("t1 no late write", 32'd0, 32'd0);

      // 2: mult
      issue("t2", 4'd1, 32'hFFFFFFFF, 32'd2);
      wait_idle(n);
      check("t2 busy cycles", n, 32'd5);
      check_hilo("t2", 32'hFFFFFFFF, 32'hFFFFFFFE);

      // 3: multu
      issue("t3", 4'd2, 32'hFFFFFFFF, 32'd2);
      wait_idle(n);
      check("t3 busy cycles", n, 32'd5);
      check_hilo("t3", 32'd1, 32'hFFFFFFFE);

      // 4: signed divide
      issue("t4", 4'd3, 32'hFFFFFFF9, 32'd2);
      wait_idle(n);
      check("t4 busy cycles", n, 32'd10);
      check_hilo("t4", 32'hFFFFFFFF, 32'hFFFFFFFD);

      // 5: unsigned divide
      issue("t5", 4'd4, 32'd7, 32'd2);
      wait_idle(n);
      check_hilo("t5", 32'd1, 32'd3);

      // 6: divide by zero keeps HI/LO
      move_to(4'd7, 32'd5);
      move_to(4'd8, 32'd6);
      issue("t6", 4'd3, 32'd9, 32'd0);
      wait_idle(n);
      check("t6 busy cycles", n, 32'd10);
      check_hilo("t6", 32'd5, 32'd6);

      // 7: mult with req blocked
      req = 1'b1; MDUOp = 4'd1; A = 32'd3; B = 32'd3; #1;
      check("t7 start", {31'd0, start}, 32'd0);
      step();
      req = 1'b0; MDUOp = 4'd0; #1;
      check("t7 busy", {31'd0, busy}, 32'd0);
      check_hilo("t7", 32'd5, 32'd6);

      // 8: req during busy does not cancel
      issue("t8", 4'd1, 32'd3, 32'd4);
      req = 1'b1; step(); step(); req = 1'b0;
      wait_idle(n);
      check("t8 busy cycles", n + 2, 32'd5);
      check_hilo("t8", 32'd0, 32'd12);

      // 9: mthi/mfhi, and mtlo suppressed by req
      move_to(4'd7, 32'h1234);
      MDUOp = 4'd5; #1;
      check("t9 mfhi", out, 32'h1234);
      req = 1'b1; MDUOp = 4'd8; A = 32'hDEAD; #1;
      step();
      req = 1'b0; MDUOp = 4'd0;
      check_hilo("t9", 32'h1234, 32'd12);

      // 10: mult while busy is ignored
      issue("t10", 4'd2, 32'd3, 32'd5);
      MDUOp = 4'd1; A = 32'd100; B = 32'd100; #1;
      check("t10 start blocked", {31'd0, start}, 32'd0);
      step();
      MDUOp = 4'd0;
      wait_idle(n);
      check("t10 busy cycles", n + 1, 32'd5);
      check_hilo("t10", 32'd0, 32'd15);
      check("t10 idle busy", {31'd0, busy}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
